axis2chnl_pktbuf: RTL and testbench
===================================

// Module: axis2chnl_pktbuf
// PURPOSE
//  Store-and-forward packet buffer feeding the RIFFA TX path. Accepts an AXI-stream with tlast
//  but no length and buffers each whole packet. Emits the packet with tuser = {tx_last, len in
//  32-bit words} valid from the first beat. Output drives the s_axis_in side of chnl2axis,
//  which needs the length before the first data word.
// PARAMETERS
//  C_PCI_DATA_WIDTH  32   data width; 32, 64 or 128 (multiple of 32)
//  C_DEPTH           512  data buffer depth in beats; power of 2, >= 4
//  C_MAX_PKTS        16   length-FIFO depth (committed packets held); power of 2, >= 2
// PORTS
//  CLK                 in   1    clock
//  RST_N               in   1    asynchronous active-low reset
//  s_axis_in_tdata     in   W    upstream data (W = C_PCI_DATA_WIDTH)
//  s_axis_in_tlast     in   1    last beat of packet
//  s_axis_in_tvalid    in   1    upstream valid
//  s_axis_in_tready    out  1    buffer can accept a beat
//  m_axis_out_tdata    out  W    buffered data to chnl2axis
//  m_axis_out_tlast    out  1    last beat of buffered packet
//  m_axis_out_tvalid   out  1    beat valid (only for fully committed packets)
//  m_axis_out_tready   in   1    downstream ready
//  m_axis_out_tuser    out  33   {1'b1, beats*(W/32)}; constant for every beat of a packet
//  pkt_split           out  1    one-cycle pulse: input packet force-split at C_DEPTH beats
//  pkts_pending        out  log2(C_MAX_PKTS)+1  committed packets not yet fully read
// BEHAVIOUR
//  Reset (RST_N low, async): all pointers/counters 0; s_axis_in_tready=0; m_axis_out_tvalid=0,
//   tlast=0, tdata=0, tuser=0; pkt_split=0; pkts_pending=0. A partially written or partially
//   read packet is discarded. tready rises on the first CLK edge after RST_N deasserts.
//  Input side: tready = (data buffer occupancy < C_DEPTH) && (pkts_pending incl. in-commit
//   < C_MAX_PKTS). A beat is written when tvalid&&tready. An input beat counter (width
//   log2(C_DEPTH)+1) counts beats of the open packet.
//  Commit: on the accepted beat with tlast=1, or on the accepted beat that brings the counter to
//   C_DEPTH (forced split; pkt_split pulses the next cycle), the beat count is pushed to the
//   length FIFO and the counter clears. Data after a forced split starts a new packet.
//  Zero-beat packets are impossible; length field = beats*(W/32), zero-extended to 32 bits.
//  Output FSM: IDLE -> LOAD when length FIFO non-empty; LOAD prefetches the first beat and
//   latches tuser; -> SEND with tvalid=1. In SEND each tvalid&&tready advances; the beat where
//   out-count == beats-1 has tlast=1. On that handshake, pop the length FIFO: -> LOAD if another
//   packet is committed, else -> IDLE.
//  Latency: commit at edge T with output IDLE -> m_axis_out_tvalid=1 at edge T+2. Within a
//   packet, sustained 1 beat/cycle while tready=1; at most 1 idle cycle between packets.
//  tvalid, once high, stays high with tdata/tlast/tuser stable until handshake (AXIS rule).
//   tvalid is never asserted for a packet whose tlast/split has not been committed.
//  Simultaneous commit and final-beat pop in one cycle: pkts_pending unchanged. Simultaneous
//   write and read: occupancy unchanged.
//  Occupancy = wr_ptr - rd_ptr with an extra wrap bit. Full when MSBs differ and the rest are
//   equal; pointers wrap modulo C_DEPTH. Space is freed as beats are read, not when the packet
//   completes.
//  Because of forced split, a full buffer always holds at least one committed packet, so no
//   deadlock is possible.
// TESTING
//  1) W=32, send 4-beat pkt D0..D3 (tlast on D3), out tready=1 -> tvalid 2 cycles after D3;
//     tuser=33'h1_0000_0004 on all beats; tlast on D3 only; data in order.
//  2) W=64, 3-beat pkt -> tuser[31:0]=6; then 1-beat pkt -> tuser=33'h1_0000_0002, tlast on
//     its only beat.
//  3) C_DEPTH=8, 20-beat pkt, out tready=0 until input stalls -> tready=0 after 8 beats;
//     pkt_split pulses; release tready -> outputs 8, 8, 4 (tuser len 8, 8, 4), 2 split pulses.
//  4) C_MAX_PKTS=2, push three 1-beat pkts with out tready=0 -> tready=0 after 2nd commit;
//     pkts_pending=2; after one pop, 3rd accepted.
//  5) Back-to-back 16-beat pkts, both sides ready every cycle -> no output bubble within a
//     packet, <=1 between packets; tready randomly toggled -> outputs held stable while stalled.
//  6) Assert RST_N low mid-output of pkt 2 -> all outputs 0 asynchronously; after release, new
//     pkt 5 beats -> tuser len 5, no stale data emitted.

Source files
------------

// File: rtl/axis2chnl_pktbuf.sv
// Store-and-forward packet buffer: holds each whole AXI-stream packet, then replays it with
// tuser = {1'b1, length in 32-bit words} valid from the first beat.
module axis2chnl_pktbuf #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int C_DEPTH          = 512,
  parameter int C_MAX_PKTS       = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_PCI_DATA_WIDTH-1:0]   s_axis_in_tdata,
  input  logic                          s_axis_in_tlast,
  input  logic                          s_axis_in_tvalid,
  output logic                          s_axis_in_tready,
  output logic [C_PCI_DATA_WIDTH-1:0]   m_axis_out_tdata,
  output logic                          m_axis_out_tlast,
  output logic                          m_axis_out_tvalid,
  input  logic                          m_axis_out_tready,
  output logic [32:0]                   m_axis_out_tuser,
  output logic                          pkt_split,
  output logic [$clog2(C_MAX_PKTS):0]   pkts_pending
);

  localparam int          AW      = $clog2(C_DEPTH);
  localparam int          PW      = $clog2(C_MAX_PKTS);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(C_DEPTH);
  localparam logic [AW:0] ONE_A   = (AW+1)'(1);
  localparam logic [AW:0] TWO_A   = (AW+1)'(2);
  localparam logic [PW:0] MAXP_L  = (PW+1)'(C_MAX_PKTS);
  localparam logic [PW:0] ONE_P   = (PW+1)'(1);
  localparam logic [31:0] WORDS_L = 32'(C_PCI_DATA_WIDTH / 32);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2} state_t;

  logic [C_PCI_DATA_WIDTH-1:0] r_mem  [C_DEPTH];
  logic [AW:0]                 r_lmem [C_MAX_PKTS];
  logic [AW:0]                 r_wr_ptr, r_rd_ptr, r_in_cnt, r_out_cnt, r_len;
  logic [PW:0]                 r_lf_wr, r_lf_rd, r_pend;
  state_t                      r_state;
  logic                        r_tready, r_tvalid, r_tlast, r_split;
  logic [C_PCI_DATA_WIDTH-1:0] r_tdata;
  logic [32:0]                 r_tuser;

  logic                        w_acc, w_full_pkt, w_push, w_hs, w_pop, w_rd_adv;
  logic [AW:0]                 w_wr_ptr_nx, w_rd_ptr_nx, w_occ_nx, w_in_cnt_inc, w_head_len;
  logic [PW:0]                 w_lf_wr_nx, w_lf_rd_nx, w_pend_nx;
  logic [31:0]                 w_len32;
  logic [C_PCI_DATA_WIDTH-1:0] w_rd_data;

  assign w_acc        = s_axis_in_tvalid && r_tready;
  assign w_full_pkt   = (r_in_cnt == (DEPTH_L - ONE_A));
  assign w_push       = w_acc && (s_axis_in_tlast || w_full_pkt);
  assign w_in_cnt_inc = r_in_cnt + ONE_A;
  assign w_hs         = r_tvalid && m_axis_out_tready;
  assign w_pop        = (r_state == S_SEND) && w_hs && r_tlast;
  // The prefetch in LOAD and every non-final handshake consume one stored beat.
  assign w_rd_adv     = (r_state == S_LOAD) || ((r_state == S_SEND) && w_hs && !r_tlast);
  assign w_wr_ptr_nx  = w_acc    ? (r_wr_ptr + ONE_A) : r_wr_ptr;
  assign w_rd_ptr_nx  = w_rd_adv ? (r_rd_ptr + ONE_A) : r_rd_ptr;
  assign w_lf_wr_nx   = w_push   ? (r_lf_wr + ONE_P)  : r_lf_wr;
  assign w_lf_rd_nx   = w_pop    ? (r_lf_rd + ONE_P)  : r_lf_rd;
  assign w_occ_nx     = w_wr_ptr_nx - w_rd_ptr_nx;
  assign w_pend_nx    = w_lf_wr_nx - w_lf_rd_nx;
  assign w_rd_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_len   = r_lmem[r_lf_rd[PW-1:0]];
  assign w_len32      = {{(31-AW){1'b0}}, w_head_len};

  assign s_axis_in_tready  = r_tready;
  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tlast  = r_tlast;
  assign m_axis_out_tvalid = r_tvalid;
  assign m_axis_out_tuser  = r_tuser;
  assign pkt_split         = r_split;
  assign pkts_pending      = r_pend;

  // Data and length storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (w_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= s_axis_in_tdata;
    end
    if (w_push) begin
      r_lmem[r_lf_wr[PW-1:0]] <= w_in_cnt_inc;
    end
  end

  // Input side: write pointer, open-packet beat count, commits and registered ready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_in_cnt <= '0;
      r_lf_wr  <= '0;
      r_pend   <= '0;
      r_tready <= 1'b0;
      r_split  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nx;
      r_lf_wr  <= w_lf_wr_nx;
      r_pend   <= w_pend_nx;
      if (w_push) begin
        r_in_cnt <= '0;
      end else if (w_acc) begin
        r_in_cnt <= w_in_cnt_inc;
      end else begin
        r_in_cnt <= r_in_cnt;
      end
      r_split  <= w_acc && w_full_pkt && !s_axis_in_tlast;
      // Ready reflects next-cycle state, so a full buffer never accepts an extra beat.
      r_tready <= (w_occ_nx < DEPTH_L) && (w_pend_nx < MAXP_L);
    end
  end

  // Output FSM: prefetch the head packet's first beat, then stream it with stable tuser.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_rd_ptr  <= '0;
      r_lf_rd   <= '0;
      r_out_cnt <= '0;
      r_len     <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
      r_tuser   <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nx;
      r_lf_rd  <= w_lf_rd_nx;
      case (r_state)
        S_IDLE: begin
          if (r_lf_wr != r_lf_rd) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_tdata   <= w_rd_data;
          r_tuser   <= {1'b1, w_len32 * WORDS_L};
          r_len     <= w_head_len;
          r_tlast   <= (w_head_len == ONE_A);
          r_out_cnt <= '0;
          r_tvalid  <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_hs && r_tlast) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            // A commit landing in the same cycle counts, keeping the inter-packet gap to one.
            r_state  <= (w_pend_nx != '0) ? S_LOAD : S_IDLE;
          end else if (w_hs) begin
            r_tdata   <= w_rd_data;
            r_out_cnt <= r_out_cnt + ONE_A;
            r_tlast   <= ((r_out_cnt + TWO_A) == r_len);
          end else begin
            r_state <= S_SEND;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis2chnl_pktbuf.sv
// Bench for axis2chnl_pktbuf: two instances (W=32/D=8/M=4 and W=64/D=32/M=2) driven by directed
// and random packets, outputs scored against a packet-level reference queue.
module tb_axis2chnl_pktbuf;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [32:0] u;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv [2];
  logic        il [2];
  logic        ordy [2];
  logic [31:0] a_id;
  logic [63:0] b_id;
  wire         irdy [2];
  wire         ov [2];
  wire         ol [2];
  wire         spl [2];
  wire  [31:0] a_od;
  wire  [63:0] b_od;
  wire  [32:0] a_ou, b_ou;
  wire  [2:0]  a_pend;
  wire  [1:0]  b_pend;
  wire  [63:0] od [2];
  wire  [32:0] ou [2];

  assign od[0] = {32'd0, a_od};
  assign od[1] = b_od;
  assign ou[0] = a_ou;
  assign ou[1] = b_ou;

  axis2chnl_pktbuf #(.C_PCI_DATA_WIDTH(32), .C_DEPTH(8), .C_MAX_PKTS(4)) u_a (
    .CLK(clk), .RST_N(rst_n),
    .s_axis_in_tdata(a_id), .s_axis_in_tlast(il[0]), .s_axis_in_tvalid(iv[0]),
    .s_axis_in_tready(irdy[0]),
    .m_axis_out_tdata(a_od), .m_axis_out_tlast(ol[0]), .m_axis_out_tvalid(ov[0]),
    .m_axis_out_tready(ordy[0]), .m_axis_out_tuser(a_ou),
    .pkt_split(spl[0]), .pkts_pending(a_pend)
  );

  axis2chnl_pktbuf #(.C_PCI_DATA_WIDTH(64), .C_DEPTH(32), .C_MAX_PKTS(2)) u_b (
    .CLK(clk), .RST_N(rst_n),
    .s_axis_in_tdata(b_id), .s_axis_in_tlast(il[1]), .s_axis_in_tvalid(iv[1]),
    .s_axis_in_tready(irdy[1]),
    .m_axis_out_tdata(b_od), .m_axis_out_tlast(ol[1]), .m_axis_out_tvalid(ov[1]),
    .m_axis_out_tready(ordy[1]), .m_axis_out_tuser(b_ou),
    .pkt_split(spl[1]), .pkts_pending(b_pend)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  string       nm [2]      = '{"a", "b"};
  int          depth_c [2] = '{8, 32};
  int          words_c [2] = '{1, 2};
  logic [63:0] openq [2][$];
  beat_t       expq [2][$];
  int          splits_exp [2] = '{0, 0};
  int          splits_seen [2] = '{0, 0};
  int          pkts_out [2] = '{0, 0};
  logic        hold [2];
  logic [63:0] hd [2];
  logic        hl [2];
  logic [32:0] hu [2];
  logic        rec = 1'b0;
  int          stamp_q [$];
  logic        stamp_l [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rdata(input int s);
    if (s == 0) return {32'd0, $urandom()};
    else        return {$urandom(), $urandom()};
  endfunction

  // Reference: a packet closes on tlast or when it reaches the buffer depth.
  task automatic model_accept(input int s, input logic [63:0] d, input logic l);
    int n;
    openq[s].push_back(d);
    n = openq[s].size();
    if (l || n == depth_c[s]) begin
      if (!l) splits_exp[s]++;
      for (int i = 0; i < n; i++) begin
        beat_t b;
        b.d = openq[s][i];
        b.l = (i == n - 1);
        b.u = {1'b1, 32'(n * words_c[s])};
        expq[s].push_back(b);
      end
      openq[s].delete();
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [63:0] d, input logic l);
    iv[s] = v;
    il[s] = l;
    if (s == 0) a_id = d[31:0];
    else        b_id = d;
  endtask

  task automatic send_beat(input int s, input logic [63:0] d, input logic l);
    int   w;
    logic ok;
    w  = 0;
    ok = 1'b0;
    set_in(s, 1'b1, d, l);
    while (!ok && w < 300) begin
      @(negedge clk);
      if (irdy[s]) ok = 1'b1;
      else w++;
    end
    if (ok) begin
      @(posedge clk); #1;
      model_accept(s, d, l);
    end else begin
      chk({nm[s], "_in_timeout"}, 64'(ok), 64'd1);
    end
    set_in(s, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic send_pkt(input int s, input int n);
    for (int i = 0; i < n; i++) send_beat(s, rdata(s), i == n - 1);
  endtask

  task automatic wait_valid(input int s, input int bound);
    int w;
    w = 0;
    while (!ov[s] && w < bound) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm[s], "_wait_valid"}, 64'(ov[s]), 64'd1);
  endtask

  task automatic drain(input int s);
    int w;
    w = 0;
    while ((expq[s].size() != 0 || ov[s]) && w < 800) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm[s], "_drain"}, 64'(expq[s].size()), 64'd0);
  endtask

  task automatic run_random(input int s, input int npk);
    logic done;
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < npk; p++) begin
          int n;
          n = (s == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 40));
          for (int i = 0; i < n; i++) begin
            send_beat(s, rdata(s), i == n - 1);
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk); #1;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ordy[s] = ($urandom_range(0, 2) != 0);
        end
      end
    join
    ordy[s] = 1'b1;
    drain(s);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: scoreboard compare, AXIS hold-stability, split pulse count.
  initial begin
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        beat_t e;
        if (!rst_n) begin
          hold[s] = 1'b0;
        end else begin
          if (hold[s]) begin
            chk({nm[s], "_stall_valid"}, 64'(ov[s]), 64'd1);
            chk({nm[s], "_stall_data"}, od[s], hd[s]);
            chk({nm[s], "_stall_last"}, 64'(ol[s]), 64'(hl[s]));
            chk({nm[s], "_stall_user"}, 64'(ou[s]), 64'(hu[s]));
          end
          if (spl[s]) splits_seen[s]++;
          if (ov[s]) begin
            chk({nm[s], "_valid_committed"}, 64'(expq[s].size() != 0), 64'd1);
            if (ordy[s] && expq[s].size() != 0) begin
              e = expq[s].pop_front();
              chk({nm[s], "_data"}, od[s], e.d);
              chk({nm[s], "_last"}, 64'(ol[s]), 64'(e.l));
              chk({nm[s], "_user"}, 64'(ou[s]), 64'(e.u));
              if (s == 1 && rec) begin
                stamp_q.push_back(cyc);
                stamp_l.push_back(e.l);
              end
              if (e.l) pkts_out[s]++;
            end
          end
          hold[s] = ov[s] && !ordy[s];
          hd[s]   = od[s];
          hl[s]   = ol[s];
          hu[s]   = ou[s];
        end
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      set_in(s, 1'b0, 64'd0, 1'b0);
      ordy[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk({nm[s], "_rst_tready"}, 64'(irdy[s]), 64'd0);
      chk({nm[s], "_rst_tvalid"}, 64'(ov[s]), 64'd0);
      chk({nm[s], "_rst_tlast"}, 64'(ol[s]), 64'd0);
      chk({nm[s], "_rst_tdata"}, od[s], 64'd0);
      chk({nm[s], "_rst_tuser"}, 64'(ou[s]), 64'd0);
      chk({nm[s], "_rst_split"}, 64'(spl[s]), 64'd0);
    end
    chk("a_rst_pend", 64'(a_pend), 64'd0);
    chk("b_rst_pend", 64'(b_pend), 64'd0);
    rst_n = 1'b1;
    chk("a_tready_before_edge", 64'(irdy[0]), 64'd0);
    @(posedge clk); #1;
    chk("a_tready_after_rst", 64'(irdy[0]), 64'd1);
    chk("b_tready_after_rst", 64'(irdy[1]), 64'd1);

    // 4-beat packet, W=32: tvalid two edges after the tlast commit.
    ordy[0] = 1'b1;
    send_pkt(0, 4);
    chk("a_lat_t0", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    chk("a_lat_t1", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    chk("a_lat_t2", 64'(ov[0]), 64'd1);
    chk("a_lat_user", 64'(ou[0]), 64'h1_0000_0004);
    chk("a_first_not_last", 64'(ol[0]), 64'd0);
    drain(0);
    chk("a_pkts_t1", 64'(pkts_out[0]), 64'd1);

    // 20 beats into an 8-deep buffer with output stalled: forced splits 8, 8, 4.
    ordy[0] = 1'b0;
    base = pkts_out[0];
    for (int i = 0; i < 8; i++) send_beat(0, rdata(0), 1'b0);
    chk("a_full_tready", 64'(irdy[0]), 64'd0);
    chk("a_full_pend", 64'(a_pend), 64'd1);
    @(posedge clk); #1;
    chk("a_split_first", 64'(splits_seen[0]), 64'd1);
    ordy[0] = 1'b1;
    for (int i = 8; i < 20; i++) send_beat(0, rdata(0), i == 19);
    drain(0);
    chk("a_split_total", 64'(splits_seen[0]), 64'd2);
    chk("a_split_model", 64'(splits_seen[0]), 64'(splits_exp[0]));
    chk("a_split_pkts", 64'(pkts_out[0] - base), 64'd3);

    // W=64: 3 beats -> 6 words, 1 beat -> 2 words.
    ordy[1] = 1'b1;
    send_pkt(1, 3);
    wait_valid(1, 10);
    chk("b_user_3beat", 64'(ou[1]), 64'h1_0000_0006);
    drain(1);
    send_pkt(1, 1);
    wait_valid(1, 10);
    chk("b_user_1beat", 64'(ou[1]), 64'h1_0000_0002);
    chk("b_last_1beat", 64'(ol[1]), 64'd1);
    drain(1);

    // Length FIFO of two: third packet waits for a pop.
    ordy[1] = 1'b0;
    send_pkt(1, 1);
    send_pkt(1, 1);
    chk("b_maxpkt_tready", 64'(irdy[1]), 64'd0);
    chk("b_maxpkt_pend", 64'(b_pend), 64'd2);
    wait_valid(1, 10);
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    chk("b_pop_pend", 64'(b_pend), 64'd1);
    chk("b_pop_tready", 64'(irdy[1]), 64'd1);
    send_pkt(1, 1);
    chk("b_third_pend", 64'(b_pend), 64'd2);
    ordy[1] = 1'b1;
    drain(1);
    chk("b_final_pend", 64'(b_pend), 64'd0);

    // Back-to-back 16-beat packets with both sides always ready.
    stamp_q.delete();
    stamp_l.delete();
    rec = 1'b1;
    send_pkt(1, 16);
    send_pkt(1, 16);
    drain(1);
    rec = 1'b0;
    chk("b_b2b_beats", 64'(stamp_q.size()), 64'd32);
    for (int i = 1; i < stamp_q.size(); i++) begin
      if (stamp_l[i-1]) chk("b_b2b_gap_between", 64'(stamp_q[i] - stamp_q[i-1] <= 2), 64'd1);
      else              chk("b_b2b_gap_within", 64'(stamp_q[i] - stamp_q[i-1]), 64'd1);
    end

    run_random(0, 10);
    run_random(1, 6);
    chk("a_split_model_rand", 64'(splits_seen[0]), 64'(splits_exp[0]));
    chk("b_split_model_rand", 64'(splits_seen[1]), 64'(splits_exp[1]));

    // Asynchronous reset in the middle of the second packet's output.
    ordy[0] = 1'b1;
    base = pkts_out[0];
    send_pkt(0, 3);
    send_pkt(0, 6);
    for (int w = 0; w < 100 && !(pkts_out[0] == base + 1 && expq[0].size() <= 4); w++) begin
      @(posedge clk); #1;
    end
    chk("a_mid_pkt2_valid", 64'(ov[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_async_tvalid", 64'(ov[0]), 64'd0);
    chk("a_async_tlast", 64'(ol[0]), 64'd0);
    chk("a_async_tdata", od[0], 64'd0);
    chk("a_async_tuser", 64'(ou[0]), 64'd0);
    chk("a_async_tready", 64'(irdy[0]), 64'd0);
    chk("a_async_pend", 64'(a_pend), 64'd0);
    chk("b_async_tready", 64'(irdy[1]), 64'd0);
    for (int s = 0; s < 2; s++) begin
      expq[s].delete();
      openq[s].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("a_tready_after_rst2", 64'(irdy[0]), 64'd1);
    base = pkts_out[0];
    send_pkt(0, 5);
    wait_valid(0, 10);
    chk("a_rst_new_user", 64'(ou[0]), 64'h1_0000_0005);
    drain(0);
    chk("a_rst_new_pkts", 64'(pkts_out[0] - base), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
